// File: rtl/light_mode_if.sv
// Lamp/mode controller bus: raw user inputs toward the controller, lamp and indicator outputs back.
interface light_mode_if;
    logic push_button;
    logic infravermelho;
    logic saida;
    logic led;
    logic timer_busy;

    modport master (
        output push_button,
        output infravermelho,
        input  saida,
        input  led,
        input  timer_busy
    );

    modport slave (
        input  push_button,
        input  infravermelho,
        output saida,
        output led,
        output timer_busy
    );
endinterface

// File: rtl/light_mode_controller.sv
// Smart-lighting mode/lamp sequencer: input sync, button debounce, short/long press
// classification and the AUTO/MANUAL state machine with a motion hold timer.
module light_mode_controller #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 200,
    parameter int HOLD_CYCLES       = 2000
) (
    input logic         clk,
    input logic         rst,
    light_mode_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PR_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int TM_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] AUTO_IDLE = 2'd0;
    localparam logic [1:0] AUTO_ON   = 2'd1;
    localparam logic [1:0] MAN_OFF   = 2'd2;
    localparam logic [1:0] MAN_ON    = 2'd3;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_MAX  = PR_W'(LONG_PRESS_CYCLES);
    localparam logic [TM_W-1:0] TM_LOAD = TM_W'(HOLD_CYCLES);

    logic            btn_s1_q, btn_s_q, ir_s1_q, ir_s_q;
    logic            btn_db_q, btn_db_d, btn_db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [PR_W-1:0] press_cnt_q, press_cnt_d;
    logic [1:0]      state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            saida_q, led_q, busy_q;
    logic            long_evt, short_evt;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) btn_db_d = btn_s_q;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end

        press_cnt_d = '0;
        if (btn_db_q) press_cnt_d = (press_cnt_q == PR_MAX) ? PR_MAX : press_cnt_q + 1'b1;

        // press_cnt only advances while btn_db is high, so the two events can never coincide
        long_evt  = btn_db_q && (press_cnt_q == PR_MAX - 1'b1);
        short_evt = btn_db_prev_q && !btn_db_q && (press_cnt_q < PR_MAX);
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            AUTO_IDLE: begin
                if (long_evt) state_d = MAN_OFF;
                else if (ir_s_q) begin
                    state_d = AUTO_ON;
                    timer_d = TM_LOAD;
                end
            end
            AUTO_ON: begin
                if (long_evt)                 state_d = MAN_ON;
                else if (ir_s_q)              timer_d = TM_LOAD;
                else if (timer_q <= TM_W'(1)) state_d = AUTO_IDLE;
                else                          timer_d = timer_q - 1'b1;
            end
            MAN_OFF: begin
                if (long_evt)       state_d = AUTO_IDLE;
                else if (short_evt) state_d = MAN_ON;
            end
            MAN_ON: begin
                if (long_evt) begin
                    state_d = AUTO_ON;
                    timer_d = TM_LOAD;
                end else if (short_evt) state_d = MAN_OFF;
            end
            default: state_d = AUTO_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q      <= 1'b0;
            btn_s_q       <= 1'b0;
            ir_s1_q       <= 1'b0;
            ir_s_q        <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            press_cnt_q   <= '0;
            state_q       <= AUTO_IDLE;
            timer_q       <= '0;
            saida_q       <= 1'b0;
            led_q         <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            btn_s1_q      <= bus.push_button;
            btn_s_q       <= btn_s1_q;
            ir_s1_q       <= bus.infravermelho;
            ir_s_q        <= ir_s1_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            db_cnt_q      <= db_cnt_d;
            press_cnt_q   <= press_cnt_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            // outputs decoded from the next state so they change on the same edge as it
            saida_q       <= (state_d == AUTO_ON) || (state_d == MAN_ON);
            led_q         <= (state_d == AUTO_ON) || (state_d == AUTO_IDLE);
            busy_q        <= (state_d == AUTO_ON) && !ir_s_q;
        end
    end

    assign bus.saida      = saida_q;
    assign bus.led        = led_q;
    assign bus.timer_busy = busy_q;
endmodule

// File: tb/tb_light_mode_controller.sv
// Bench for light_mode_controller: directed scenarios plus random button/IR traffic,
// checked every cycle against a mode/lamp reference model.
module tb_light_mode_controller;
    localparam int DEB  = 16;
    localparam int LONG = 200;
    localparam int HOLD = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    light_mode_if ifc ();

    light_mode_controller #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .HOLD_CYCLES      (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode bit, lamp bit and remaining hold time.
    bit m_ok = 0;
    bit m_s1b, m_sb, m_s1i, m_si, m_db, m_prev;
    int m_run, m_plen, m_hold;
    bit m_auto, m_lamp, m_busy;
    int n_short = 0;
    int n_long  = 0;

    always @(posedge clk) begin
        bit lng, sh, ir;
        if (rst) begin
            m_s1b = 0; m_sb = 0; m_s1i = 0; m_si = 0; m_db = 0; m_prev = 0;
            m_run = 0; m_plen = 0; m_hold = 0;
            m_auto = 1; m_lamp = 0; m_busy = 0; m_ok = 1;
        end else begin
            ir  = m_si;
            lng = 0;
            sh  = 0;
            if (!m_db) begin
                sh     = m_prev && (m_plen < LONG);
                m_plen = 0;
            end else begin
                m_plen++;
                lng = (m_plen == LONG);
            end
            m_prev = m_db;
            if (m_sb != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db  = m_sb;
                    m_run = 0;
                end
            end else m_run = 0;
            m_sb  = m_s1b;
            m_s1b = ifc.push_button;
            m_si  = m_s1i;
            m_s1i = ifc.infravermelho;
            n_short += int'(sh);
            n_long  += int'(lng);
            // a long press flips the mode and keeps the lamp as it is
            if (lng) begin
                m_auto = !m_auto;
                m_hold = HOLD;
            end else if (sh) begin
                if (!m_auto) m_lamp = !m_lamp;
            end else if (m_auto) begin
                if (ir) begin
                    m_lamp = 1;
                    m_hold = HOLD;
                end else if (m_lamp) begin
                    m_hold--;
                    if (m_hold == 0) m_lamp = 0;
                end
            end
            m_busy = m_auto && m_lamp && !ir;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("model_saida", ifc.saida, m_lamp);
            check("model_led", ifc.led, m_auto);
            check("model_busy", ifc.timer_busy, m_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int len);
        ifc.push_button = 1'b1;
        cyc(len);
        ifc.push_button = 1'b0;
    endtask

    task automatic wait_lamp_off(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (ifc.saida === 1'b0) seen = 1;
        end
        check(name, seen, 1'b1);
    endtask

    initial begin
        int s0, l0;
        ifc.push_button   = 1'b1;
        ifc.infravermelho = 1'b1;

        // T1: reset with inputs high, then button held across release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_saida", ifc.saida, 1'b0);
            check("rst_led", ifc.led, 1'b1);
            check("rst_busy", ifc.timer_busy, 1'b0);
        end
        rst = 1'b0;
        ifc.infravermelho = 1'b0;
        for (int i = 0; i < 2 + DEB; i++) begin
            @(negedge clk);
            check("held_led", ifc.led, 1'b1);
            check("held_saida", ifc.saida, 1'b0);
        end
        ifc.push_button = 1'b0;
        cyc(60);

        // T2: IR-to-lamp latency, hold time, retrigger
        ifc.infravermelho = 1'b1;
        cyc(2);
        check("ir_lat_2", ifc.saida, 1'b0);
        cyc(1);
        check("ir_lat_3", ifc.saida, 1'b1);
        cyc(2);
        ifc.infravermelho = 1'b0;
        cyc(HOLD + 1);
        check("hold_last", ifc.saida, 1'b1);
        cyc(1);
        check("hold_fall", ifc.saida, 1'b0);
        ifc.infravermelho = 1'b1;
        cyc(5);
        ifc.infravermelho = 1'b0;
        cyc(HOLD - 100);
        check("countdown_busy", ifc.timer_busy, 1'b1);
        ifc.infravermelho = 1'b1;
        cyc(1);
        ifc.infravermelho = 1'b0;
        cyc(HOLD + 1);
        check("retrig_last", ifc.saida, 1'b1);
        cyc(1);
        check("retrig_fall", ifc.saida, 1'b0);
        cyc(10);

        // T3: bouncing button then one clean short press in AUTO_IDLE
        s0 = n_short;
        l0 = n_long;
        for (int i = 0; i < 10; i++) begin
            ifc.push_button = ~ifc.push_button;
            cyc(3);
        end
        press(100);
        cyc(60);
        check_int("bounce_shorts", n_short - s0, 1);
        check_int("bounce_longs", n_long - l0, 0);
        check("bounce_led", ifc.led, 1'b1);
        check("bounce_saida", ifc.saida, 1'b0);

        // T4: long press to MAN_OFF, short presses toggle the lamp, IR ignored
        s0 = n_short;
        press(250);
        cyc(40);
        check_int("long_no_short", n_short - s0, 0);
        check("man_off_led", ifc.led, 1'b0);
        check("man_off_saida", ifc.saida, 1'b0);
        press(50);
        cyc(40);
        check("man_on_saida", ifc.saida, 1'b1);
        for (int i = 0; i < 60; i++) begin
            ifc.infravermelho = 1'($urandom_range(0, 1));
            cyc(1);
        end
        ifc.infravermelho = 1'b0;
        cyc(5);
        check("man_ir_saida", ifc.saida, 1'b1);
        check("man_ir_led", ifc.led, 1'b0);
        press(50);
        cyc(40);
        check("man_off2_saida", ifc.saida, 1'b0);
        press(50);
        cyc(40);

        // T5: long press in MAN_ON returns to AUTO_ON with countdown running
        press(250);
        cyc(40);
        check("ret_led", ifc.led, 1'b1);
        check("ret_saida", ifc.saida, 1'b1);
        check("ret_busy", ifc.timer_busy, 1'b1);
        wait_lamp_off("ret_hold_fall", HOLD);
        cyc(10);

        // T6: reset mid-countdown with the button held
        ifc.infravermelho = 1'b1;
        cyc(5);
        ifc.infravermelho = 1'b0;
        cyc(500);
        check("pre_rst_busy", ifc.timer_busy, 1'b1);
        ifc.push_button = 1'b1;
        cyc(30);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_saida", ifc.saida, 1'b0);
        check("mid_rst_led", ifc.led, 1'b1);
        check("mid_rst_busy", ifc.timer_busy, 1'b0);
        cyc(100);
        ifc.push_button = 1'b0;
        cyc(60);

        // Random traffic
        for (int seg = 0; seg < 24; seg++) begin
            int lens[5] = '{4, 12, 60, 150, 240};
            int gap;
            ifc.infravermelho = 1'($urandom_range(0, 1));
            press(lens[$urandom_range(0, 4)]);
            gap = int'($urandom_range(30, 400));
            for (int i = 0; i < gap; i++) begin
                if ($urandom_range(0, 15) == 0) ifc.infravermelho = ~ifc.infravermelho;
                cyc(1);
            end
        end
        ifc.infravermelho = 1'b0;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
